// File: rtl/acq_sequencer.sv
// rtl/acq_sequencer.sv - pre/post-trigger capture sequencer writing two-channel samples into a circular BRAM
// Optional macro TRIGGER_HYSTERESIS_EN adds the TRIG_HYST port and a hysteresis-qualified trigger.
module acq_sequencer #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16
) (
  input  logic                DCLK,
  input  logic                RESET,
  input  logic                SAMPLE_VALID,
  input  logic [DATA_W-1:0]   SAMPLE_CH0,
  input  logic [DATA_W-1:0]   SAMPLE_CH1,
  input  logic                ARM,
  input  logic                ABORT,
  input  logic                FORCE,
  input  logic                TRIG_SRC,
  input  logic                TRIG_SLOPE,
  input  logic [DATA_W-1:0]   TRIG_LEVEL,
  input  logic [ADDR_W-1:0]   PRE_COUNT,
  input  logic [ADDR_W-1:0]   POST_COUNT,
`ifdef TRIGGER_HYSTERESIS_EN
  input  logic [DATA_W-1:0]   TRIG_HYST,
`endif
  output logic                WR_EN,
  output logic [ADDR_W-1:0]   WR_ADDR,
  output logic [2*DATA_W-1:0] WR_DATA,
  output logic [ADDR_W-1:0]   TRIG_ADDR,
  output logic [ADDR_W-1:0]   START_ADDR,
  output logic                BUSY,
  output logic                DONE,
  output logic                CFG_ERR
);
  typedef enum logic [2:0] {S_IDLE, S_FILL, S_ARMED, S_POST, S_DONE} state_t;

  localparam logic [ADDR_W:0]   DEPTH = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W-1:0] ONE   = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t              state, state_n;
  logic [ADDR_W-1:0]   wr_ptr, cnt, pre_q, post_q;
  logic                trig_src_q, trig_slope_q, force_pend;
  logic [DATA_W-1:0]   level_q, sel;
  logic [ADDR_W:0]     cfg_sum;
  logic                idle_or_done, arm_go, arm_rej, take, edge_hit, trig, last_pre, last_post;
`ifdef TRIGGER_HYSTERESIS_EN
  logic                hyst_flag;
  logic [DATA_W-1:0]   hyst_lo, hyst_hi;
  logic [DATA_W:0]     hi_sum;
`else
  logic                prev_valid;
  logic [DATA_W-1:0]   prev_sel;
`endif

  always_comb begin
    idle_or_done = (state == S_IDLE) || (state == S_DONE);
    cfg_sum      = {1'b0, PRE_COUNT} + {1'b0, POST_COUNT} + {{ADDR_W{1'b0}}, 1'b1};
    arm_go       = ARM && !ABORT && idle_or_done && (cfg_sum <= DEPTH);
    arm_rej      = ARM && !ABORT && idle_or_done && (cfg_sum > DEPTH);
    // samples arriving with ARM or ABORT are dropped so a new capture starts clean
    take         = SAMPLE_VALID && !ARM && !ABORT && !idle_or_done;
    sel          = trig_src_q ? SAMPLE_CH1 : SAMPLE_CH0;
`ifdef TRIGGER_HYSTERESIS_EN
    hyst_lo      = (level_q > TRIG_HYST) ? (level_q - TRIG_HYST) : '0;
    hi_sum       = {1'b0, level_q} + {1'b0, TRIG_HYST};
    hyst_hi      = hi_sum[DATA_W] ? '1 : hi_sum[DATA_W-1:0];
    edge_hit     = hyst_flag && (trig_slope_q ? (sel < level_q) : (sel >= level_q));
`else
    edge_hit     = prev_valid && (trig_slope_q ? ((prev_sel >= level_q) && (sel < level_q))
                                               : ((prev_sel < level_q) && (sel >= level_q)));
`endif
    trig         = take && (state == S_ARMED) && (edge_hit || force_pend);
    last_pre     = take && (state == S_FILL) && ((cnt + ONE) == pre_q);
    last_post    = take && (state == S_POST) && ((cnt + ONE) == post_q);

    state_n = state;
    if (ABORT) begin
      state_n = S_IDLE;
    end else begin
      case (state)
        S_IDLE, S_DONE: if (arm_go) state_n = (PRE_COUNT == '0) ? S_ARMED : S_FILL;
        S_FILL:         if (last_pre) state_n = S_ARMED;
        S_ARMED:        if (trig) state_n = (post_q == '0) ? S_DONE : S_POST;
        S_POST:         if (last_post) state_n = S_DONE;
        default:        state_n = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge DCLK or posedge RESET) begin
    if (RESET) state <= S_IDLE;
    else       state <= state_n;
  end

  always_ff @(posedge DCLK or posedge RESET) begin
    if (RESET) begin
      WR_EN        <= 1'b0;
      WR_ADDR      <= '0;
      WR_DATA      <= '0;
      TRIG_ADDR    <= '0;
      START_ADDR   <= '0;
      CFG_ERR      <= 1'b0;
      wr_ptr       <= '0;
      cnt          <= '0;
      pre_q        <= '0;
      post_q       <= '0;
      trig_src_q   <= 1'b0;
      trig_slope_q <= 1'b0;
      level_q      <= '0;
      force_pend   <= 1'b0;
`ifdef TRIGGER_HYSTERESIS_EN
      hyst_flag    <= 1'b0;
`else
      prev_valid   <= 1'b0;
      prev_sel     <= '0;
`endif
    end else begin
      WR_EN <= take;
      if (take) begin
        WR_ADDR <= wr_ptr;
        WR_DATA <= {SAMPLE_CH1, SAMPLE_CH0};
        wr_ptr  <= wr_ptr + ONE;
`ifdef TRIGGER_HYSTERESIS_EN
        if (trig_slope_q ? (sel >= hyst_hi) : (sel < hyst_lo)) hyst_flag <= 1'b1;
`else
        prev_sel   <= sel;
        prev_valid <= 1'b1;
`endif
      end
      if (take && ((state == S_FILL) || (state == S_POST))) cnt <= cnt + ONE;
      if (arm_go) begin
        trig_src_q   <= TRIG_SRC;
        trig_slope_q <= TRIG_SLOPE;
        level_q      <= TRIG_LEVEL;
        pre_q        <= PRE_COUNT;
        post_q       <= POST_COUNT;
        cnt          <= '0;
        CFG_ERR      <= 1'b0;
`ifdef TRIGGER_HYSTERESIS_EN
        hyst_flag    <= 1'b0;
`else
        prev_valid   <= 1'b0;
`endif
      end else if (arm_rej) begin
        CFG_ERR <= 1'b1;
      end
      if (trig) begin
        cnt       <= '0;
        TRIG_ADDR <= wr_ptr;
        if (post_q == '0) START_ADDR <= wr_ptr - pre_q;
`ifdef TRIGGER_HYSTERESIS_EN
        hyst_flag <= 1'b0;
`endif
      end
      if (last_post) START_ADDR <= TRIG_ADDR - pre_q;
      if (FORCE && (state == S_ARMED)) force_pend <= 1'b1;
      if (ABORT || arm_go || trig) force_pend <= 1'b0;
    end
  end

  assign BUSY = !idle_or_done;
  assign DONE = (state == S_DONE);
endmodule
